uart_line_buffer: RTL and testbench



---
 rtl/uart_line_buffer_pkg.sv | 32 +++
 rtl/uart_line_ram.sv | 55 +++++
 rtl/uart_line_buffer.sv | 135 +++++++++++++
 tb/tb_uart_line_buffer.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_line_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_buffer_pkg
// Description : Shared UART constants: line terminator bytes, line-buffer
//               FSM encodings, default clock/baud settings.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_line_buffer_pkg;

    // Byte width of every UART data path
    localparam int unsigned c_byte_w   = 8;

    // Line control characters
    localparam logic [7:0]  c_eol_byte = 8'h0A;
    localparam logic [7:0]  c_cr_byte  = 8'h0D;

    // Line buffer FSM encodings
    localparam logic [0:0]  c_st_fill  = 1'b0;
    localparam logic [0:0]  c_st_drain = 1'b1;

    // Default clock and baud used by the UART rx/tx blocks
    localparam int unsigned c_clk_hz   = 50_000_000;
    localparam int unsigned c_baud     = 115_200;

    // Rounded number of system clocks per UART bit
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + (baud / 2)) / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_ram
// Description : DEPTH x 8 register array, synchronous write port and a
//               registered read port with write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_ram
    import uart_line_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [c_byte_w-1:0] wr_data,
    input  logic [AW-1:0]       rd_addr,
    output logic [c_byte_w-1:0] rd_data
);

    logic [c_byte_w-1:0] mem_q [DEPTH];
    logic [c_byte_w-1:0] rd_data_q;
    logic [c_byte_w-1:0] rd_data_d;

    // Storage array; contents are never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read mux; a same-cycle write to the read address is forwarded so a
    // one-byte line can be played back the cycle after it is written
    always_comb begin
        rd_data_d = mem_q[rd_addr];
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data_d = wr_data;
        end
    end

    // Registered read data, cleared by reset so out_data starts at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/uart_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : uart_line_buffer
// Description : Collects received UART bytes into a line (terminator, full
//               buffer or idle timeout) and replays the line on a
//               valid/ready stream towards the transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_line_buffer
    import uart_line_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 64,
    parameter logic [7:0]  EOL        = c_eol_byte,
    parameter int unsigned IDLE_FLUSH = 0,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [AW:0] line_len,
    output logic        busy,
    output logic        drop_pulse
);

    localparam logic [AW:0] c_last_idx   = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] c_ptr_one    = (AW+1)'(1);
    localparam logic [31:0] c_idle_limit = 32'(IDLE_FLUSH);

    logic [0:0]  state_q,      state_d;
    logic [AW:0] wr_ptr_q,     wr_ptr_d;
    logic [AW:0] rd_ptr_q,     rd_ptr_d;
    logic [AW:0] line_len_q,   line_len_d;
    logic [31:0] idle_cnt_q,   idle_cnt_d;
    logic        drop_pulse_q, drop_pulse_d;

    logic        w_accept;
    logic        w_handshake;

    assign w_accept    = in_valid  && (state_q == c_st_fill);
    assign w_handshake = out_ready && (state_q == c_st_drain);

    // Next-state logic for the fill/drain line controller
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        line_len_d   = line_len_q;
        idle_cnt_d   = idle_cnt_q;
        drop_pulse_d = in_valid && (state_q != c_st_fill);

        case (state_q)
            c_st_fill: begin
                if (w_accept) begin
                    wr_ptr_d   = wr_ptr_q + c_ptr_one;
                    idle_cnt_d = '0;
                    if ((in_data == EOL) || (wr_ptr_q == c_last_idx)) begin
                        line_len_d = wr_ptr_q + c_ptr_one;
                        state_d    = c_st_drain;
                    end
                end else if (wr_ptr_q == '0) begin
                    idle_cnt_d = '0;
                end else if (c_idle_limit != 32'd0) begin
                    // Flush on the edge that completes the IDLE_FLUSH-th
                    // consecutive idle cycle; the counter parks at the limit
                    if ((idle_cnt_q + 32'd1) >= c_idle_limit) begin
                        idle_cnt_d = c_idle_limit;
                        line_len_d = wr_ptr_q;
                        state_d    = c_st_drain;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 32'd1;
                    end
                end
            end
            default: begin
                if (w_handshake) begin
                    if (rd_ptr_q == (line_len_q - c_ptr_one)) begin
                        state_d    = c_st_fill;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        line_len_d = '0;
                    end else begin
                        rd_ptr_d = rd_ptr_q + c_ptr_one;
                    end
                end
            end
        endcase
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= c_st_fill;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            line_len_q   <= '0;
            idle_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            line_len_q   <= line_len_d;
            idle_cnt_q   <= idle_cnt_d;
            drop_pulse_q <= drop_pulse_d;
        end
    end

    // Reading at the next read pointer keeps out_data one step ahead, so the
    // following byte is presented the cycle after each handshake
    uart_line_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_accept),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr_d[AW-1:0]),
        .rd_data (out_data)
    );

    assign in_ready   = (state_q == c_st_fill);
    assign busy       = (state_q == c_st_drain);
    assign out_valid  = (state_q == c_st_drain);
    assign line_len   = line_len_q;
    assign drop_pulse = drop_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_line_buffer
// Description : Self-checking bench for uart_line_buffer (DEPTH=8,
//               IDLE_FLUSH=100) with directed scenarios and random lines
//               checked against a line-splitting reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_line_buffer;

    localparam int         DEPTH = 8;
    localparam int         IDLE  = 100;
    localparam int         AW    = $clog2(DEPTH);
    localparam logic [7:0] EOL   = 8'h0A;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [7:0]  in_data   = 8'h00;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [AW:0] line_len;
    logic        busy;
    logic        drop_pulse;

    int checks = 0;
    int errors = 0;

    uart_line_buffer #(
        .DEPTH      (DEPTH),
        .EOL        (EOL),
        .IDLE_FLUSH (IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .line_len   (line_len),
        .busy       (busy),
        .drop_pulse (drop_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse of in_valid; reports whether the block was ready
    task automatic send_byte(input logic [7:0] b, output bit accepted);
        accepted = (in_ready === 1'b1);
        in_data  = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Plays the current line out, optionally offering junk bytes meanwhile;
    // counts cycles where drop_pulse disagrees with the previous offer
    task automatic drain(input int ready_pct, input int offer_pct,
                         input logic [7:0] offer_byte,
                         output logic [7:0] got[$], output int dp_err,
                         output bit tout);
        bit prev_offer;
        got        = {};
        dp_err     = 0;
        tout       = 1'b1;
        prev_offer = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (drop_pulse !== prev_offer) dp_err++;
            if (out_valid !== 1'b1) begin
                tout = 1'b0;
                break;
            end
            out_ready  = ($urandom_range(99) < ready_pct);
            in_valid   = ($urandom_range(99) < offer_pct);
            in_data    = offer_byte;
            prev_offer = in_valid;
            if (out_ready) got.push_back(out_data);
            tick();
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    function automatic bit q_eq(input logic [7:0] a[$], input logic [7:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic string q_str(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%h ", q[i])};
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
        checks++; if (line_len !== '0) begin errors++; $display("FAIL reset_line_len got %0d exp 0", line_len); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", drop_pulse); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_line();
        logic [7:0] got[$];
        logic [7:0] exp[$];
        bit a0, a1, a2, tout;
        int dp;
        exp = {8'h41, 8'h42, 8'h0A};
        send_byte(8'h41, a0);
        send_byte(8'h42, a1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_busy_early got %b exp 0", busy); end
        send_byte(8'h0A, a2);
        checks++; if (!(a0 && a1 && a2)) begin errors++; $display("FAIL ab_accept got %b%b%b exp 111", a0, a1, a2); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL ab_first_out got v=%b d=%h exp v=1 d=41", out_valid, out_data); end
        checks++; if (line_len !== 4'd3) begin errors++; $display("FAIL ab_line_len got %0d exp 3", line_len); end
        drain(100, 0, 8'h00, got, dp, tout);
        checks++; if (!q_eq(got, exp) || tout) begin errors++; $display("FAIL ab_data got %s exp %s", q_str(got), q_str(exp)); end
        checks++; if (in_ready !== 1'b1 || line_len !== '0) begin errors++; $display("FAIL ab_return got rdy=%b len=%0d exp rdy=1 len=0", in_ready, line_len); end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [7:0] exp[$];
        bit a, tout;
        int dp;
        exp = {8'h41, 8'h42, 8'h0A};
        foreach (exp[i]) send_byte(exp[i], a);
        for (int c = 0; c < 5; c++) begin
            out_ready = 1'b0;
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin errors++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=41", c, out_valid, out_data); end
        end
        drain(50, 0, 8'h00, got, dp, tout);
        checks++; if (!q_eq(got, exp) || tout) begin errors++; $display("FAIL bp_data got %s exp %s", q_str(got), q_str(exp)); end
    endtask

    task automatic test_full_and_drop();
        logic [7:0] got[$];
        logic [7:0] exp[$];
        bit a, all_acc, tout;
        int dp;
        exp = {};
        all_acc = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            exp.push_back(8'(i));
            send_byte(8'(i), a);
            all_acc &= a;
            if (i == DEPTH - 1) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_early got %b exp 0", busy); end
            end
        end
        checks++; if (!all_acc) begin errors++; $display("FAIL full_accept got 0 exp 1"); end
        checks++; if (busy !== 1'b1 || line_len !== 4'(DEPTH)) begin errors++; $display("FAIL full_start got busy=%b len=%0d exp busy=1 len=%0d", busy, line_len, DEPTH); end
        drain(60, 50, 8'h09, got, dp, tout);
        checks++; if (!q_eq(got, exp) || tout) begin errors++; $display("FAIL full_data got %s exp %s", q_str(got), q_str(exp)); end
        checks++; if (dp != 0) begin errors++; $display("FAIL full_drop_pulse got %0d bad cycles exp 0", dp); end
    endtask

    task automatic test_eol_at_depth();
        logic [7:0] got[$];
        logic [7:0] exp[$];
        bit a, tout;
        int dp;
        exp = {};
        for (int i = 0; i < DEPTH - 1; i++) exp.push_back(8'h61 + 8'(i));
        exp.push_back(EOL);
        foreach (exp[i]) send_byte(exp[i], a);
        checks++; if (busy !== 1'b1 || line_len !== 4'(DEPTH)) begin errors++; $display("FAIL eoldepth_len got busy=%b len=%0d exp busy=1 len=%0d", busy, line_len, DEPTH); end
        drain(80, 0, 8'h00, got, dp, tout);
        checks++; if (!q_eq(got, exp) || tout) begin errors++; $display("FAIL eoldepth_data got %s exp %s", q_str(got), q_str(exp)); end
    endtask

    task automatic test_lone_eol();
        bit a;
        send_byte(EOL, a);
        checks++; if (line_len !== 4'd1 || out_valid !== 1'b1 || out_data !== EOL) begin errors++; $display("FAIL lone_start got len=%0d v=%b d=%h exp len=1 v=1 d=0a", line_len, out_valid, out_data); end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h09;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || line_len !== '0) begin errors++; $display("FAIL lone_end got v=%b rdy=%b len=%0d exp v=0 rdy=1 len=0", out_valid, in_ready, line_len); end
        checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL lone_last_drop got %b exp 1", drop_pulse); end
        tick();
        checks++; if (drop_pulse !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL lone_after got drop=%b busy=%b exp drop=0 busy=0", drop_pulse, busy); end
    endtask

    task automatic test_idle_flush();
        logic [7:0] got[$];
        bit a, tout;
        int dp, cnt;
        send_byte(8'h58, a);
        cnt = 0;
        while (busy !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        checks++; if (cnt != IDLE) begin errors++; $display("FAIL idle_latency got %0d cycles exp %0d", cnt, IDLE); end
        checks++; if (line_len !== 4'd1) begin errors++; $display("FAIL idle_len got %0d exp 1", line_len); end
        drain(100, 0, 8'h00, got, dp, tout);
        checks++; if (got.size() != 1 || got[0] !== 8'h58 || tout) begin errors++; $display("FAIL idle_data got %s exp 58", q_str(got)); end
    endtask

    task automatic test_reset_mid_drain();
        logic [7:0] got[$];
        logic [7:0] exp[$];
        bit a, tout;
        int dp;
        send_byte(8'h41, a);
        send_byte(8'h42, a);
        send_byte(EOL, a);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ctrl got v=%b busy=%b rdy=%b exp 0 0 1", out_valid, busy, in_ready); end
        checks++; if (out_data !== 8'h00 || line_len !== '0 || drop_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_data got d=%h len=%0d drop=%b exp 00 0 0", out_data, line_len, drop_pulse); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp = {8'h5A, EOL};
        foreach (exp[i]) send_byte(exp[i], a);
        drain(100, 0, 8'h00, got, dp, tout);
        checks++; if (!q_eq(got, exp) || tout) begin errors++; $display("FAIL rstmid_after got %s exp %s", q_str(got), q_str(exp)); end
    endtask

    // Random lines; the model splits the byte stream at the first EOL or at
    // DEPTH bytes, otherwise expects an idle flush after IDLE quiet cycles
    task automatic test_random_lines();
        logic [7:0] src[$];
        logic [7:0] exp[$];
        logic [7:0] got[$];
        logic [7:0] b;
        bit ended, a, all_acc, tout;
        int n, dp, cnt;
        for (int l = 0; l < 25; l++) begin
            src = {};
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(99) < 12) b = EOL;
                else begin
                    b = 8'($urandom_range(255));
                    if (b == EOL) b = 8'h0B;
                end
                src.push_back(b);
            end
            exp = {};
            ended = 1'b0;
            foreach (src[i]) begin
                if (!ended) begin
                    exp.push_back(src[i]);
                    if (src[i] == EOL || exp.size() == DEPTH) ended = 1'b1;
                end
            end
            all_acc = 1'b1;
            foreach (exp[i]) begin
                repeat ($urandom_range(0, 3)) tick();
                send_byte(exp[i], a);
                all_acc &= a;
            end
            checks++; if (!all_acc) begin errors++; $display("FAIL rnd%0d_accept got 0 exp 1", l); end
            if (!ended) begin
                cnt = 0;
                while (busy !== 1'b1 && cnt < 300) begin
                    tick();
                    cnt++;
                end
                checks++; if (cnt != IDLE) begin errors++; $display("FAIL rnd%0d_idle got %0d cycles exp %0d", l, cnt, IDLE); end
            end else begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rnd%0d_busy got %b exp 1", l, busy); end
            end
            checks++; if (line_len !== 4'(exp.size())) begin errors++; $display("FAIL rnd%0d_len got %0d exp %0d", l, line_len, exp.size()); end
            drain($urandom_range(30, 100), 30, 8'($urandom_range(255)), got, dp, tout);
            checks++; if (!q_eq(got, exp) || tout) begin errors++; $display("FAIL rnd%0d_data got %s exp %s", l, q_str(got), q_str(exp)); end
            checks++; if (dp != 0) begin errors++; $display("FAIL rnd%0d_drop got %0d bad cycles exp 0", l, dp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_backpressure();
        test_full_and_drop();
        test_eol_at_depth();
        test_lone_eol();
        test_idle_flush();
        test_reset_mid_drain();
        test_random_lines();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
